// File: rtl/sfu_sched_pkg.sv
// Shared types and sizing helpers for the SFU processing-element scheduler.
package sfu_sched_pkg;

   // Issue-side sequencing around fence ops.
   typedef enum logic [1:0] {
      StRun,
      StDrain,
      StFenceWait
   } sched_state_e;

   localparam int unsigned DefaultPeCount    = 3;
   localparam int unsigned DefaultMaxInflight = 4;

   // Index width for n items; at least one bit so a single PE still has a select.
   function automatic int unsigned sel_bits(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a counter that must reach max_inflight inclusive.
   function automatic int unsigned cnt_bits(int unsigned max_inflight);
      return (max_inflight > 0) ? $clog2(max_inflight + 1) : 1;
   endfunction

   // Width of the sum of all per-PE counters.
   function automatic int unsigned total_bits(int unsigned n, int unsigned max_inflight);
      return $clog2(n * max_inflight + 1);
   endfunction

endpackage

// File: rtl/sfu_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index; the priority pointer only moves when the
// granted request is actually accepted downstream.
module sfu_rr_arbiter
   import sfu_sched_pkg::*;
#(
   parameter int unsigned N = DefaultPeCount,
   localparam int unsigned IDX_W = sel_bits(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             accept,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   logic [IDX_W-1:0] ptr_q;

   function automatic logic [IDX_W-1:0] wrap(int unsigned v);
      return IDX_W'(v % N);
   endfunction

   // Scan upwards from the pointer, wrapping, and pick the first active requester.
   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      for (int unsigned off = 0; off < N; off++) begin
         if (!valid && req[wrap(32'(ptr_q) + off)]) begin
            valid = 1'b1;
            idx   = wrap(32'(ptr_q) + off);
         end
      end
      if (valid) begin
         grant[idx] = 1'b1;
      end
   end

   // Winner drops to lowest priority once its request has been taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (accept && valid) begin
         ptr_q <= wrap(32'(idx) + 1);
      end
   end

endmodule

// File: rtl/sfu_pe_scheduler.sv
// Steers SFU requests to processing elements under per-PE credit limits, serialises fence
// ops against everything else in flight, and merges PE results into one registered stream.
module sfu_pe_scheduler
   import sfu_sched_pkg::*;
#(
   parameter int unsigned PE_COUNT     = DefaultPeCount,
   parameter int unsigned REQ_WIDTH    = 64,
   parameter int unsigned RSP_WIDTH    = 64,
   parameter int unsigned MAX_INFLIGHT = DefaultMaxInflight,
   localparam int unsigned PE_SEL_BITS = sel_bits(PE_COUNT)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          req_valid,
   input  logic [PE_SEL_BITS-1:0]        req_pe_sel,
   input  logic                          req_fence,
   input  logic [REQ_WIDTH-1:0]          req_data,
   output logic                          req_ready,
   output logic [PE_COUNT-1:0]           pe_req_valid,
   output logic [REQ_WIDTH-1:0]          pe_req_data,
   input  logic [PE_COUNT-1:0]           pe_req_ready,
   input  logic [PE_COUNT-1:0]           pe_rsp_valid,
   input  logic [PE_COUNT*RSP_WIDTH-1:0] pe_rsp_data,
   output logic [PE_COUNT-1:0]           pe_rsp_ready,
   output logic                          rsp_valid,
   output logic [RSP_WIDTH-1:0]          rsp_data,
   output logic [PE_SEL_BITS-1:0]        rsp_pe,
   input  logic                          rsp_ready,
   output logic                          busy
);

   localparam int unsigned CNT_W = cnt_bits(MAX_INFLIGHT);
   localparam int unsigned TOT_W = total_bits(PE_COUNT, MAX_INFLIGHT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

   logic                   run_q;
   sched_state_e           state_q;
   logic [CNT_W-1:0]       cnt_q [PE_COUNT];
   logic [TOT_W-1:0]       total;
   logic                   sel_ok;
   logic                   cnt_full;
   logic                   fsm_ok;
   logic                   can_issue;
   logic [PE_COUNT-1:0]    issue_vec;
   logic [PE_COUNT-1:0]    retire_vec;
   logic [PE_COUNT-1:0]    dec_vec;
   logic [PE_COUNT-1:0]    nz_vec;
   logic [PE_COUNT-1:0]    grant;
   logic [PE_SEL_BITS-1:0] win_idx;
   logic                   win_valid;
   logic                   out_accept;
   logic                   rsp_valid_q;
   logic [RSP_WIDTH-1:0]   rsp_data_q;
   logic [PE_SEL_BITS-1:0] rsp_pe_q;

   // Held low through reset and for the first edge after release so handshakes start cleanly.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_q <= 1'b0;
      end else begin
         run_q <= 1'b1;
      end
   end

   // Total outstanding ops and per-PE nonzero flags from the registered counters.
   always_comb begin
      total  = '0;
      nz_vec = '0;
      for (int unsigned i = 0; i < PE_COUNT; i++) begin
         total     = total + TOT_W'(cnt_q[i]);
         nz_vec[i] = (cnt_q[i] != '0);
      end
   end

   // Credit check on the selected PE; an out-of-range select is treated as full.
   always_comb begin
      sel_ok   = (32'(req_pe_sel) < PE_COUNT);
      cnt_full = 1'b1;
      if (sel_ok) begin
         cnt_full = (cnt_q[req_pe_sel] == CNT_MAX);
      end
   end

   // Fence ordering: fences wait for an empty SFU, and nothing passes an unretired fence.
   always_comb begin
      fsm_ok = 1'b0;
      unique case (state_q)
         StRun:       fsm_ok = !req_fence || (total == '0);
         StDrain:     fsm_ok = (total == '0);
         StFenceWait: fsm_ok = 1'b0;
         default:     fsm_ok = 1'b0;
      endcase
   end

   // Zero-latency combinational issue path.
   always_comb begin
      can_issue    = run_q && req_valid && sel_ok && !cnt_full && fsm_ok;
      pe_req_valid = '0;
      req_ready    = 1'b0;
      if (can_issue) begin
         pe_req_valid[req_pe_sel] = 1'b1;
         req_ready                = pe_req_ready[req_pe_sel];
      end
   end

   assign pe_req_data = req_data;
   assign issue_vec   = pe_req_valid & pe_req_ready;

   // Result merge: take a new result whenever the output register is empty or draining.
   assign out_accept   = run_q && (!rsp_valid_q || rsp_ready);
   assign pe_rsp_ready = grant & {PE_COUNT{out_accept}};
   assign retire_vec   = pe_rsp_valid & pe_rsp_ready;
   // A stray result from an idle PE must not wrap its counter.
   assign dec_vec      = retire_vec & nz_vec;

   sfu_rr_arbiter #(
      .N (PE_COUNT)
   ) u_rsp_arb (
      .clk    (clk),
      .rst_n  (reset),
      .req    (pe_rsp_valid & {PE_COUNT{run_q}}),
      .accept (out_accept),
      .grant  (grant),
      .idx    (win_idx),
      .valid  (win_valid)
   );

   // Per-PE credit counters; simultaneous issue and retire cancel out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < PE_COUNT; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < PE_COUNT; i++) begin
            if (issue_vec[i] && !dec_vec[i]) begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end else if (!issue_vec[i] && dec_vec[i]) begin
               cnt_q[i] <= cnt_q[i] - 1'b1;
            end
         end
      end
   end

   // Fence sequencing state machine.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StRun;
      end else begin
         unique case (state_q)
            StRun: begin
               if (run_q && req_valid && req_fence && sel_ok) begin
                  if (total != '0) begin
                     state_q <= StDrain;
                  end else if (req_ready) begin
                     state_q <= StFenceWait;
                  end
               end
            end
            StDrain: begin
               if (req_ready) begin
                  state_q <= StFenceWait;
               end
            end
            StFenceWait: begin
               // Only the fence is outstanding here, so its retire empties the SFU.
               if ((total == TOT_W'(1)) && (|retire_vec)) begin
                  state_q <= StRun;
               end
            end
            default: state_q <= StRun;
         endcase
      end
   end

   // One-entry output buffer; holds while the consumer stalls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_pe_q    <= '0;
      end else if (win_valid && out_accept) begin
         rsp_valid_q <= 1'b1;
         rsp_data_q  <= pe_rsp_data[32'(win_idx) * RSP_WIDTH +: RSP_WIDTH];
         rsp_pe_q    <= win_idx;
      end else if (rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_pe    = rsp_pe_q;
   assign busy      = (total != '0) || (state_q != StRun);

   // A stalled request must keep its payload.
   a_req_stable: assert property (@(posedge clk) disable iff (!reset)
      (req_valid && !req_ready) |=> $stable(req_data));

   // Results may only come from PEs that have work outstanding.
   a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
      (retire_vec & ~nz_vec) == '0);

   a_sel_range: assert property (@(posedge clk) disable iff (!reset)
      req_valid |-> sel_ok);

endmodule
